// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 framebuffer path: bus widths, FTDI frame
// header bytes, the unpacker state encoding and the RGB-to-word packing that
// both the FTDI write side and the display gamma path rely on.
package hub75_pkg;

  // Framebuffer word address and data widths
  localparam int FB_AW = 14;
  localparam int FB_DW = 20;

  // Two-byte frame header sent by the host ahead of every frame
  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  // Frame unpacker states
  typedef enum logic [1:0] {
    ST_HUNT0   = 2'd0,
    ST_HUNT1   = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_COMMIT  = 2'd3
  } unpack_state_e;

  // Pack one RGB byte triple into a framebuffer word: 7 bits red, 7 bits
  // green, 6 bits blue, dropping the least significant bits of each.
  function automatic logic [FB_DW-1:0] pack_rgb(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r[7:1], g[7:1], b[7:2]};
  endfunction

endpackage

// File: rtl/ftdi_frame_unpacker.sv
// FTDI byte stream to framebuffer writer. Hunts for the A5 5A header, packs
// every R,G,B byte triple into one framebuffer word written at sequential
// addresses of the back bank, flips the bank select when a frame completes,
// and aborts a partial frame when the byte stream stalls.
module ftdi_frame_unpacker
  import hub75_pkg::*;
#(
  parameter int DEPTH   = 16384,  // words per frame
  parameter int TIMEOUT = 4096    // idle cycles inside a frame before abort
) (
  input  logic             clk_60,
  input  logic             rst,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic [FB_DW-1:0] fb_wdata,
  output logic [FB_AW-1:0] fb_waddr,
  output logic             fb_we,
  output logic             fb_sel,
  output logic             frame_done,
  output logic             sync_err,
  output logic [7:0]       err_count
);

  localparam int                TW        = $clog2(TIMEOUT);
  localparam logic [FB_AW-1:0]  LAST_ADDR = FB_AW'(DEPTH - 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);

  unpack_state_e    state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [FB_AW-1:0] addr_q, addr_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [FB_DW-1:0] fb_wdata_q, fb_wdata_d;
  logic [FB_AW-1:0] fb_waddr_q, fb_waddr_d;
  logic             fb_we_q, fb_we_d;
  logic             fb_sel_q, fb_sel_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic [7:0]       err_count_q;
  logic [TW-1:0]    tmo_q;
  logic             in_frame;
  logic             timeout_hit;

  // The inter-byte watchdog only runs while a frame is being received
  assign in_frame    = (state_q == ST_HUNT1) || (state_q == ST_PAYLOAD);
  assign timeout_hit = in_frame && !byte_valid && (tmo_q == TMO_LAST);

  // Next-state and registered-output logic for the header/payload FSM
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    r_d          = r_q;
    g_d          = g_q;
    fb_wdata_d   = fb_wdata_q;
    fb_waddr_d   = fb_waddr_q;
    fb_we_d      = 1'b0;
    fb_sel_d     = fb_sel_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    unique case (state_q)
      // COMMIT lasts one cycle; a byte landing there is judged as a HUNT0 byte
      ST_HUNT0, ST_COMMIT: begin
        state_d = ST_HUNT0;
        if (byte_valid && (byte_data == HDR0)) begin
          state_d = ST_HUNT1;
        end
      end

      ST_HUNT1: begin
        if (byte_valid) begin
          if (byte_data == HDR1) begin
            state_d = ST_PAYLOAD;
            addr_d  = '0;
            phase_d = 2'd0;
          end else if (byte_data != HDR0) begin
            // A repeated HDR0 keeps waiting; anything else is a broken header
            state_d    = ST_HUNT0;
            sync_err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d    = ST_HUNT0;
          sync_err_d = 1'b1;
        end
      end

      ST_PAYLOAD: begin
        if (byte_valid) begin
          // Header values are ordinary pixel data here; there is no resync
          unique case (phase_q)
            2'd0: begin
              r_d     = byte_data;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = byte_data;
              phase_d = 2'd2;
            end
            default: begin
              phase_d    = 2'd0;
              fb_we_d    = 1'b1;
              fb_wdata_d = pack_rgb(r_q, g_q, byte_data);
              fb_waddr_d = addr_q;
              if (addr_q == LAST_ADDR) begin
                // Last word: the bank flip becomes visible with its write
                state_d      = ST_COMMIT;
                fb_sel_d     = ~fb_sel_q;
                frame_done_d = 1'b1;
              end else begin
                addr_d = addr_q + FB_AW'(1);
              end
            end
          endcase
        end else if (timeout_hit) begin
          // Abandon the partial frame; words already written stay in the back bank
          state_d    = ST_HUNT0;
          sync_err_d = 1'b1;
        end
      end

      default: state_d = ST_HUNT0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_60 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT0;
      phase_q      <= 2'd0;
      addr_q       <= '0;
      r_q          <= '0;
      g_q          <= '0;
      fb_wdata_q   <= '0;
      fb_waddr_q   <= '0;
      fb_we_q      <= 1'b0;
      fb_sel_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      r_q          <= r_d;
      g_q          <= g_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_waddr_q   <= fb_waddr_d;
      fb_we_q      <= fb_we_d;
      fb_sel_q     <= fb_sel_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Inter-byte watchdog: cleared by every byte and outside a frame
  always_ff @(posedge clk_60 or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (byte_valid || !in_frame || timeout_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Saturating count of sync errors, updated together with the sync_err pulse
  always_ff @(posedge clk_60 or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (sync_err_d && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign fb_wdata   = fb_wdata_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_we      = fb_we_q;
  assign fb_sel     = fb_sel_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ftdi_frame_unpacker.sv
// Bench for ftdi_frame_unpacker. A full-size instance covers the complete
// 16384-word frame and the mid-frame reset; a 128-word instance covers header
// hunting, header errors, timeout abort and error-count saturation cheaply.
module tb_ftdi_frame_unpacker;

  localparam int DEPTH_F = 16384;
  localparam int DEPTH_S = 128;
  localparam int TMO     = 4096;

  logic        clk_60 = 1'b0;
  logic        rst;
  logic [7:0]  bd_f, bd_s;
  logic        bv_f, bv_s;
  logic [19:0] wd_f, wd_s;
  logic [13:0] wa_f, wa_s;
  logic        we_f, we_s, sel_f, sel_s, fd_f, fd_s, se_f, se_s;
  logic [7:0]  ec_f, ec_s;

  int checks = 0;
  int errors = 0;
  int we_cnt_f = 0, fd_cnt_f = 0, se_cnt_f = 0;
  int we_cnt_s = 0, fd_cnt_s = 0, se_cnt_s = 0;

  // Expected writes as {valid, addr, data}
  logic [34:0] exp_f[$];
  logic [34:0] exp_s[$];

  always #8 clk_60 = ~clk_60;

  ftdi_frame_unpacker #(.DEPTH(DEPTH_F), .TIMEOUT(TMO)) dut_full (
    .clk_60(clk_60), .rst(rst), .byte_data(bd_f), .byte_valid(bv_f),
    .fb_wdata(wd_f), .fb_waddr(wa_f), .fb_we(we_f), .fb_sel(sel_f),
    .frame_done(fd_f), .sync_err(se_f), .err_count(ec_f)
  );

  ftdi_frame_unpacker #(.DEPTH(DEPTH_S), .TIMEOUT(TMO)) dut_small (
    .clk_60(clk_60), .rst(rst), .byte_data(bd_s), .byte_valid(bv_s),
    .fb_wdata(wd_s), .fb_waddr(wa_s), .fb_we(we_s), .fb_sel(sel_s),
    .frame_done(fd_s), .sync_err(se_s), .err_count(ec_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference packing written as arithmetic on the dropped-LSB channel values
  function automatic logic [19:0] ref_pack(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    int v;
    v = (int'(r) / 2) * 8192 + (int'(g) / 2) * 64 + int'(b) / 4;
    return 20'(v);
  endfunction

  // Scoreboard: every write seen must be the next expected one
  always @(negedge clk_60) begin : mon_f
    logic [34:0] e;
    if (!rst) begin
      if (we_f) begin
        we_cnt_f++;
        e = (exp_f.size() != 0) ? exp_f.pop_front() : 35'h0;
        check("full_write", {1'b1, wa_f, wd_f}, e);
      end
      if (fd_f) fd_cnt_f++;
      if (se_f) se_cnt_f++;
    end
  end

  always @(negedge clk_60) begin : mon_s
    logic [34:0] e;
    if (!rst) begin
      if (we_s) begin
        we_cnt_s++;
        e = (exp_s.size() != 0) ? exp_s.pop_front() : 35'h0;
        check("small_write", {1'b1, wa_s, wd_s}, e);
      end
      if (fd_s) fd_cnt_s++;
      if (se_s) se_cnt_s++;
    end
  end

  // Present one byte for one cycle; returns at the negedge after it was sampled
  task automatic drive(input bit sel, input logic [7:0] b);
    if (sel) begin
      bd_s = b;
      bv_s = 1'b1;
    end else begin
      bd_f = b;
      bv_f = 1'b1;
    end
    @(negedge clk_60);
    bv_f = 1'b0;
    bv_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_60);
  endtask

  task automatic send_word(input bit sel, input int addr, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b);
    logic [34:0] e;
    e = {1'b1, 14'(addr), ref_pack(r, g, b)};
    if (sel) exp_s.push_back(e);
    else     exp_f.push_back(e);
    drive(sel, r);
    drive(sel, g);
    drive(sel, b);
  endtask

  task automatic payload(input bit sel, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      send_word(sel, first + i, 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic header(input bit sel);
    drive(sel, 8'hA5);
    drive(sel, 8'h5A);
  endtask

  initial begin
    rst  = 1'b1;
    bd_f = '0;
    bd_s = '0;
    bv_f = 1'b0;
    bv_s = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_we",    we_f,  1'b0);
    check("rst_waddr", wa_f,  14'h0);
    check("rst_wdata", wd_f,  20'h0);
    check("rst_sel",   sel_f, 1'b0);
    check("rst_done",  fd_f,  1'b0);
    check("rst_serr",  se_f,  1'b0);
    check("rst_ecnt",  ec_f,  8'h0);
    check("rst_sel_s", sel_s, 1'b0);

    // Full frame at one byte per cycle; word 0 is FF,81,07
    header(0);
    send_word(0, 0, 8'hFF, 8'h81, 8'h07);
    check("w0_we",    we_f, 1'b1);
    check("w0_addr",  wa_f, 14'h0);
    check("w0_data",  wd_f, 20'hFF001);  // {7F,40,01} concatenated
    check("w0_sel",   sel_f, 1'b0);
    payload(0, 1, DEPTH_F - 1);
    check("last_we",   we_f,  1'b1);
    check("last_addr", wa_f,  14'h3FFF);
    check("last_done", fd_f,  1'b1);
    check("last_sel",  sel_f, 1'b1);
    idle(1);
    check("post_done",  fd_f, 1'b0);
    check("post_we",    we_f, 1'b0);
    check("full_nwe",   we_cnt_f, DEPTH_F);
    check("full_nfd",   fd_cnt_f, 1);
    check("full_nse",   se_cnt_f, 0);
    check("full_q",     exp_f.size(), 0);

    // Reset in the middle of word 5000 of the next frame
    header(0);
    payload(0, 0, 5000);
    drive(0, 8'h12);
    #1 rst = 1'b1;
    #1;
    check("mrst_we",   we_f,  1'b0);
    check("mrst_sel",  sel_f, 1'b0);
    check("mrst_addr", wa_f,  14'h0);
    check("mrst_data", wd_f,  20'h0);
    check("mrst_q",    exp_f.size(), 0);
    exp_f.delete();
    exp_s.delete();
    idle(1);
    rst = 1'b0;
    idle(1);
    header(0);
    send_word(0, 0, 8'h10, 8'h20, 8'h30);
    check("restart_addr", wa_f, 14'h0);
    check("restart_we",   we_f, 1'b1);
    payload(0, 1, 3);
    idle(1);
    check("restart_nwe", we_cnt_f, DEPTH_F + 5000 + 4);
    check("restart_q",   exp_f.size(), 0);

    // Leading junk and repeated HDR0 before a frame on the small instance
    drive(1, 8'h11);
    drive(1, 8'hA5);
    drive(1, 8'hA5);
    drive(1, 8'h5A);
    payload(1, 0, DEPTH_S);
    check("s1_done", fd_s,  1'b1);
    check("s1_sel",  sel_s, 1'b1);

    // Broken header; the A5 arrives during COMMIT and must count
    drive(1, 8'hA5);
    drive(1, 8'h00);
    check("herr_pulse", se_s, 1'b1);
    idle(1);
    check("herr_clear", se_s, 1'b0);
    check("herr_ecnt",  ec_s, 8'd1);
    check("herr_nse",   se_cnt_s, 1);
    check("herr_nfd",   fd_cnt_s, 1);
    header(1);
    payload(1, 0, DEPTH_S);
    idle(1);
    check("s2_sel", sel_s, 1'b0);
    check("s2_nfd", fd_cnt_s, 2);

    // Stall after 300 payload bytes: abort exactly after TIMEOUT idle cycles
    header(1);
    payload(1, 0, 100);
    idle(TMO - 8);
    check("tmo_early", se_cnt_s, 1);
    idle(16);
    check("tmo_nse",  se_cnt_s, 2);
    check("tmo_nfd",  fd_cnt_s, 2);
    check("tmo_sel",  sel_s, 1'b0);
    check("tmo_ecnt", ec_s, 8'd2);
    header(1);
    payload(1, 0, DEPTH_S);
    idle(1);
    check("s3_sel", sel_s, 1'b1);
    check("s3_nfd", fd_cnt_s, 3);
    check("s3_q",   exp_s.size(), 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 8'hA5);
      drive(1, 8'h00);
    end
    idle(1);
    check("sat_ecnt", ec_s, 8'hFF);
    check("sat_nse",  se_cnt_s, 302);

    // Mid-frame reset on the small instance, then a clean frame from addr 0
    header(1);
    payload(1, 0, 40);
    #1 rst = 1'b1;
    #1;
    check("s_mrst_ecnt", ec_s,  8'h0);
    check("s_mrst_sel",  sel_s, 1'b0);
    exp_s.delete();
    idle(1);
    rst = 1'b0;
    idle(1);
    header(1);
    payload(1, 0, DEPTH_S);
    idle(1);
    check("s4_sel",  sel_s, 1'b1);
    check("s4_nfd",  fd_cnt_s, 4);
    check("s4_q",    exp_s.size(), 0);
    check("s4_ecnt", ec_s, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
